// File: rtl/router_merge.sv
// rtl/router_merge.sv - four-source round-robin merge of single-byte packets into one output stage
// Optional ROUTER_MERGE_STATS_EN adds the saturating pkt_count accepted-packet counter port.
module router_merge (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pkt_valid,
    input  logic [7:0]  data_in0,
    input  logic [7:0]  data_in1,
    input  logic [7:0]  data_in2,
    input  logic [7:0]  data_in3,
    output logic [3:0]  ready_in,
    output logic [7:0]  data_out,
    output logic [1:0]  src_addr,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [1:0]  state_out
`ifdef ROUTER_MERGE_STATS_EN
    ,
    output logic [15:0] pkt_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEND   = 2'b01,
        HOLD   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t      state_q;
    logic [7:0]  data_q;
    logic [1:0]  src_q;
    logic [1:0]  rr_q;
    logic [1:0]  rr_d;
    logic        valid_q;
    logic [7:0]  din [4];
    logic [1:0]  win_idx;
    logic [1:0]  probe;
    logic        win_found;
    logic        accept;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    // Walk the search order backwards so the entry closest to rr_q is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        probe     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            probe = rr_q + 2'(k);
            if (pkt_valid[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    // A slot opens when the output stage is empty or is draining this very edge.
    assign accept   = rst && win_found &&
                      ((state_q == IDLE) || ((state_q == SEND) && ready_out));
    assign ready_in = accept ? (4'b0001 << win_idx) : 4'b0000;
    assign rr_d     = win_idx + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            src_q   <= 2'b00;
            rr_q    <= 2'b00;
        end else begin
            if (accept) begin
                data_q <= din[win_idx];
                src_q  <= win_idx;
                rr_q   <= rr_d;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (!ready_out) begin
                        state_q <= HOLD;
                    end else if (!accept) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (ready_out) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign src_addr  = src_q;
    assign valid_out = valid_q;
    assign state_out = state_q;

`ifdef ROUTER_MERGE_STATS_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign cnt_d = (accept && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule

// File: doc/router_merge.md
ROUTER_MERGE -- requirements
Module: router_merge

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003: pkt_valid  input  4  per-source request; bit i = source i presents a one-byte packet.
REQ-004: data_in0..data_in3  input  8 each  packet byte from source 0..3.
REQ-005: ready_in  output  4  per-source accept; one-hot or zero.
REQ-006: data_out  output  8  merged packet byte.
REQ-007: src_addr  output  2  index of the source that supplied data_out.
REQ-008: valid_out  output  1  data_out/src_addr hold a valid packet.
REQ-009: ready_out  input  1  downstream can take the packet this cycle.
REQ-010: state_out  output  2  current FSM state encoding.
REQ-011: pkt_count  output  16  accepted-packet counter; present only when ROUTER_MERGE_STATS_EN is defined.

Function
REQ-012: Packets are single beat; input transfer on a rising edge where pkt_valid[i] and ready_in[i] are both 1; output transfer on a rising edge where valid_out and ready_out are both 1.
REQ-013: FSM states: IDLE=2'b00 (output empty), SEND=2'b01 (packet presented, first cycle), HOLD=2'b10 (packet stalled); 2'b11 unused, returns to IDLE.
REQ-014: Arbitration is round-robin: search order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4); the first set pkt_valid bit wins.
REQ-015: After accepting source g, rr_ptr <= (g+1) mod 4; rr_ptr does not change on cycles with no accept.
REQ-016: IDLE: ready_in = one-hot of the winner (zero if pkt_valid==0); on accept, register data_in<g> to data_out and g to src_addr, then go to SEND.
REQ-017: SEND: valid_out=1; ready_in = winner one-hot when ready_out=1, else 0.
REQ-018: SEND with ready_out=1 and a winner: current packet leaves and the new one loads on the same edge (back-to-back, one packet per cycle); stay in SEND.
REQ-019: SEND with ready_out=1 and no request -> IDLE; SEND with ready_out=0 -> HOLD.
REQ-020: HOLD: valid_out=1, ready_in=0, data_out/src_addr stable; on ready_out=1 the packet leaves -> IDLE.
REQ-021: Latency: a packet accepted at edge N shows valid_out=1 after edge N (one cycle).
REQ-022: No packet is lost or duplicated: every input transfer produces exactly one output transfer.
REQ-023: valid_out is 1 in SEND and HOLD only; a source deasserting pkt_valid without a transfer is ignored.
REQ-024: ready_in may depend combinationally on pkt_valid and ready_out; data_out, src_addr, valid_out and state_out are registered.

Reset
REQ-025: When rst=0, immediately and regardless of clk: state=IDLE, state_out=2'b00, valid_out=0, data_out=8'h00, src_addr=2'b00, rr_ptr=0, pkt_count=0; ready_in=4'b0000 while rst=0.
REQ-026: Reset during SEND/HOLD discards the held packet; the first edge after rst returns to 1 runs IDLE behaviour.

Configuration
REQ-027: Macro ROUTER_MERGE_STATS_EN defined: pkt_count increments by 1 on each input transfer, saturates at 16'hFFFF, and is cleared by reset.
REQ-028: Macro undefined: no pkt_count port or counter logic; all other behaviour identical.

Verification
REQ-029: rst released, pkt_valid=4'b0001, data_in0=8'hAA, ready_out=1 for one cycle -> next cycle valid_out=1, data_out=8'hAA, src_addr=0, state_out=01; following cycle state_out=00.
REQ-030: pkt_valid=4'b1111 held, data_inN=8'h10+N, ready_out=1 -> outputs 8'h10, 11, 12, 13, 10 on consecutive cycles, src_addr 0,1,2,3,0.
REQ-031: Packet 8'hBB from source 1 accepted with ready_out=0 for 3 cycles -> state_out=10, data_out=8'hBB held stable, ready_in=0; ready_out=1 -> one output transfer, then state_out=00.
REQ-032: rr_ptr=2, pkt_valid=4'b0011 -> source 0 granted (ready_in=4'b0001), then source 1.
REQ-033: rst driven low mid-HOLD with no clk edge -> valid_out=0 and state_out=00 at once; with ROUTER_MERGE_STATS_EN, 5 accepted packets read pkt_count=5 before reset, 0 after.
